hasti_timer: RTL and testbench
==============================

Name: hasti_timer

Overview:
- HASTI slave responder for the core's data-side initiator traffic, hung off a spare xbar slave port alongside the UART.
- Provides a 64-bit free-running tick counter (mtime), a 64-bit compare register (mtimecmp), a programmable prescaler and a level interrupt output.
- Implements the full slave side of the two-phase bus: address-phase capture, data-phase response, ready/resp including two-cycle ERROR.

Parameters:
- PRESCALE_RESET, 32'd0, reset value of prescale register (0 = tick every clk)
- BASE_MASK, 32'h0000_001F, address bits decoded locally; all other addr bits ignored

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- sel  in  1  slave select from xbar (address phase)
- addr  in  HASTI_ADDR_WIDTH  byte address (address phase)
- read  in  1  read request (address phase)
- write  in  1  write request (address phase)
- size  in  HASTI_SIZE_WIDTH  transfer size; only word (2) legal
- burst  in  HASTI_BURST_WIDTH  ignored
- mastlock  in  1  ignored
- prot  in  HASTI_PROT_WIDTH  ignored
- wdata  in  HASTI_BUS_WIDTH  write data (data phase)
- rdata  out  HASTI_BUS_WIDTH  read data (data phase)
- ready  out  1  data phase complete / slave accepts new address
- resp  out  HASTI_RESP_WIDTH  0 OKAY, 1 ERROR
- irq  out  1  timer interrupt, level

Behaviour:
- Reset (async, resetn low): mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, ctrl=0, prescale=PRESCALE_RESET, presc_cnt=0, state=IDLE; outputs ready=1, resp=0, rdata=0, irq=0.
- Register map (addr[4:2]): 0 mtime[31:0], 1 mtime[63:32], 2 mtimecmp[31:0], 3 mtimecmp[63:32], 4 ctrl {bit1 irq_en, bit0 run}, 5 prescale; 6,7 illegal.
- Address phase accepted when sel & (read|write) & ready; captures reg index, read/write, legality (index<=5 and size==2) into data-phase registers.
- FSM states: IDLE, DATA, ERR1, ERR2.
- IDLE: accept -> DATA if legal, ERR1 if illegal.
- DATA: ready=1, resp=0; write: wdata stored at end of this cycle; read: rdata = selected register value (combinational from current regs). A new address phase may be accepted in the same cycle (back-to-back pipelining) -> DATA/ERR1, else IDLE.
- ERR1: ready=0, resp=1; -> ERR2. ERR2: ready=1, resp=1; new accept allowed as in DATA. Illegal writes have no side effect.
- Unused reads return 0 in rdata when not in a read data phase.
- Counter: when ctrl.run=1, presc_cnt increments each clk; when presc_cnt==prescale, presc_cnt<=0 and mtime<=mtime+1 (64-bit, wraps FFFF..FF->0). run=0 freezes both.
- Bus write to mtime half in the same cycle as a tick: written half takes wdata, other half takes its incremented value (carry from lo into hi suppressed if lo written).
- Write to prescale resets presc_cnt to 0.
- irq registered: irq <= irq_en & (mtime >= mtimecmp), unsigned 64-bit; 1-cycle latency after compare condition changes.
- Reads of mtime_lo/hi are not atomic; software rereads hi.

Optional Feature:
- Macro HASTI_TIMER_WAIT_STATE_EN. Defined: every legal read data phase inserts one wait state (state DWAIT, ready=0, resp=0, then DATA); writes unchanged. Undefined: zero-wait reads as above. Used to exercise initiator stall handling.

Decomposition:
- Bus widths, HASTI_RESP_OKAY/ERROR, size encodings from vscale_hasti_constants.vh; register offsets and TIMER base address added to vscale_platform_constants.vh.
- One sub-module: hasti_timer_counter (prescaler + 64-bit mtime with half-word write ports and tick output); bus FSM and compare stay in top.

Test Plan:
- Reset then read offset 0x08, 0x0C -> rdata 32'hFFFF_FFFF each, resp 0, irq 0.
- Write prescale=3, ctrl=1; wait 20 clk; read mtime_lo -> 5 (±1 per capture cycle, checked against model).
- Write mtime_lo=32'hFFFF_FFFE, mtime_hi=0, prescale=0, run; after 3 ticks read hi -> 1, lo -> 1.
- mtimecmp={0,10}, ctrl=3, mtime=0, prescale=0: irq rises exactly one clk after mtime reaches 10; write mtimecmp_lo=100 -> irq falls one clk later.
- Read offset 0x18 and byte-size read of 0x00 -> ready 0/resp 1 then ready 1/resp 1; registers unchanged.
- Back-to-back write 0x14 then read 0x14 with no idle cycle -> read returns written value, ready stays 1 (and one ready=0 cycle with HASTI_TIMER_WAIT_STATE_EN).

Source files
------------

// File: rtl/hasti_timer_pkg.sv
// Shared HASTI bus constants, timer register offsets and bus FSM state type.
package hasti_timer_pkg;

    localparam int HASTI_ADDR_WIDTH  = 32;
    localparam int HASTI_BUS_WIDTH   = 32;
    localparam int HASTI_SIZE_WIDTH  = 3;
    localparam int HASTI_BURST_WIDTH = 3;
    localparam int HASTI_PROT_WIDTH  = 4;
    localparam int HASTI_RESP_WIDTH  = 1;

    localparam logic [HASTI_SIZE_WIDTH-1:0] HASTI_SIZE_WORD  = 3'd2;
    localparam logic [HASTI_RESP_WIDTH-1:0] HASTI_RESP_OKAY  = 1'b0;
    localparam logic [HASTI_RESP_WIDTH-1:0] HASTI_RESP_ERROR = 1'b1;

    localparam logic [2:0] REG_MTIME_LO    = 3'd0;
    localparam logic [2:0] REG_MTIME_HI    = 3'd1;
    localparam logic [2:0] REG_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] REG_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] REG_CTRL        = 3'd4;
    localparam logic [2:0] REG_PRESCALE    = 3'd5;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        ERR1,
        ERR2,
        DWAIT
    } state_t;

    function automatic logic reg_legal(input logic [2:0] idx,
                                       input logic [HASTI_SIZE_WIDTH-1:0] sz);
        return (idx <= REG_PRESCALE) && (sz == HASTI_SIZE_WORD);
    endfunction

endpackage

// File: rtl/hasti_timer_counter.sv
// Prescaled 64-bit mtime counter with independent half-word write ports.
module hasti_timer_counter
    import hasti_timer_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        run,
    input  logic [31:0] prescale,
    input  logic        presc_clr,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] mtime,
    output logic        tick
);

    logic [31:0] presc_cnt;
    logic [63:0] mtime_inc;

    assign tick      = run && (presc_cnt == prescale);
    assign mtime_inc = tick ? mtime + 64'd1 : mtime;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            presc_cnt <= '0;
            mtime     <= '0;
        end else begin
            if (presc_clr)
                presc_cnt <= '0;
            else if (run)
                presc_cnt <= tick ? '0 : presc_cnt + 32'd1;
            // A written low half swallows the carry, so the high half holds.
            mtime[31:0]  <= wr_lo ? wdata : mtime_inc[31:0];
            mtime[63:32] <= wr_hi ? wdata :
                            (wr_lo ? mtime[63:32] : mtime_inc[63:32]);
        end
    end

endmodule

// File: rtl/hasti_timer.sv
// HASTI slave timer: mtime/mtimecmp/ctrl/prescale registers and level irq.
// Define HASTI_TIMER_WAIT_STATE_EN to add one wait state to every legal read.
module hasti_timer
    import hasti_timer_pkg::*;
#(
    parameter logic [31:0] PRESCALE_RESET = 32'd0,
    parameter logic [31:0] BASE_MASK      = 32'h0000_001F
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          sel,
    input  logic [HASTI_ADDR_WIDTH-1:0]   addr,
    input  logic                          read,
    input  logic                          write,
    input  logic [HASTI_SIZE_WIDTH-1:0]   size,
    input  logic [HASTI_BURST_WIDTH-1:0]  burst,
    input  logic                          mastlock,
    input  logic [HASTI_PROT_WIDTH-1:0]   prot,
    input  logic [HASTI_BUS_WIDTH-1:0]    wdata,
    output logic [HASTI_BUS_WIDTH-1:0]    rdata,
    output logic                          ready,
    output logic [HASTI_RESP_WIDTH-1:0]   resp,
    output logic                          irq
);

    state_t      state, state_nxt;
    logic [2:0]  dp_idx;
    logic        dp_write, dp_read;
    logic [63:0] mtime, mtimecmp;
    logic [1:0]  ctrl;
    logic [31:0] prescale;
    logic [31:0] addr_loc;
    logic        accept, legal, wr_en, tick;
    logic        unused_bits;

    assign addr_loc = addr & BASE_MASK;
    assign legal    = reg_legal(addr_loc[4:2], size);
    assign ready    = (state != ERR1) && (state != DWAIT);
    assign resp     = (state == ERR1 || state == ERR2) ? HASTI_RESP_ERROR : HASTI_RESP_OKAY;
    assign accept   = sel && (read || write) && ready;
    assign wr_en    = (state == DATA) && dp_write;

    assign unused_bits = ^{burst, mastlock, prot, addr_loc[31:5], addr_loc[1:0], tick};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            dp_idx   <= '0;
            dp_write <= 1'b0;
            dp_read  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                dp_idx   <= addr_loc[4:2];
                dp_write <= write;
                dp_read  <= read && !write;
            end
        end
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE, DATA, ERR2: begin
                if (accept && !legal)
                    state_nxt = ERR1;
                else if (accept)
`ifdef HASTI_TIMER_WAIT_STATE_EN
                    state_nxt = (read && !write) ? DWAIT : DATA;
`else
                    state_nxt = DATA;
`endif
            end
            ERR1:    state_nxt = ERR2;
            DWAIT:   state_nxt = DATA;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mtimecmp <= '1;
            ctrl     <= '0;
            prescale <= PRESCALE_RESET;
            irq      <= 1'b0;
        end else begin
            if (wr_en) begin
                case (dp_idx)
                    REG_MTIMECMP_LO: mtimecmp[31:0]  <= wdata;
                    REG_MTIMECMP_HI: mtimecmp[63:32] <= wdata;
                    REG_CTRL:        ctrl            <= wdata[1:0];
                    REG_PRESCALE:    prescale        <= wdata;
                    default:         ;
                endcase
            end
            irq <= ctrl[1] && (mtime >= mtimecmp);
        end
    end

    always_comb begin
        rdata = '0;
        if (state == DATA && dp_read) begin
            case (dp_idx)
                REG_MTIME_LO:    rdata = mtime[31:0];
                REG_MTIME_HI:    rdata = mtime[63:32];
                REG_MTIMECMP_LO: rdata = mtimecmp[31:0];
                REG_MTIMECMP_HI: rdata = mtimecmp[63:32];
                REG_CTRL:        rdata = {30'd0, ctrl};
                REG_PRESCALE:    rdata = prescale;
                default:         rdata = '0;
            endcase
        end
    end

    hasti_timer_counter u_counter (
        .clk       (clk),
        .resetn    (resetn),
        .run       (ctrl[0]),
        .prescale  (prescale),
        .presc_clr (wr_en && dp_idx == REG_PRESCALE),
        .wr_lo     (wr_en && dp_idx == REG_MTIME_LO),
        .wr_hi     (wr_en && dp_idx == REG_MTIME_HI),
        .wdata     (wdata),
        .mtime     (mtime),
        .tick      (tick)
    );

endmodule

// File: tb/tb_hasti_timer.sv
// Scoreboard bench for hasti_timer against an epoch-based analytical timer model.
module tb_hasti_timer;
    import hasti_timer_pkg::*;

`ifdef HASTI_TIMER_WAIT_STATE_EN
    localparam int WAIT = 1;
`else
    localparam int WAIT = 0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        sel, read, write, mastlock;
    logic [31:0] addr, wdata, rdata;
    logic [2:0]  size, burst;
    logic [3:0]  prot;
    logic        ready, irq;
    logic [0:0]  resp;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    hasti_timer #(.PRESCALE_RESET(32'd0), .BASE_MASK(32'h0000_001F)) dut (
        .clk(clk), .resetn(resetn), .sel(sel), .addr(addr), .read(read),
        .write(write), .size(size), .burst(burst), .mastlock(mastlock),
        .prot(prot), .wdata(wdata), .rdata(rdata), .ready(ready),
        .resp(resp), .irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // Timer state valid from cycle n0 onward; values at later cycles follow arithmetically.
    typedef struct {
        int                n0;
        logic [63:0]       m;
        longint unsigned   q;
        longint unsigned   p;
        bit                run;
        bit                en;
        logic [63:0]       cmp;
    } epoch_t;
    epoch_t ep[$];

    typedef struct {
        logic [31:0] rd;
        logic        resp;
        int          waits;
    } exp_t;
    exp_t sb[$];

    function automatic int find_ep(input int n);
        for (int i = ep.size() - 1; i >= 0; i--)
            if (ep[i].n0 <= n) return i;
        return 0;
    endfunction

    function automatic logic [63:0] mt_at(input int n);
        epoch_t e = ep[find_ep(n)];
        longint unsigned dt = longint'(n - e.n0);
        if (!e.run) return e.m;
        return e.m + (e.q + dt) / (e.p + 64'd1);
    endfunction

    function automatic longint unsigned q_at(input int n);
        epoch_t e = ep[find_ep(n)];
        longint unsigned dt = longint'(n - e.n0);
        if (!e.run) return e.q;
        return (e.q + dt) % (e.p + 64'd1);
    endfunction

    function automatic logic [31:0] model_read(input logic [2:0] idx, input int n);
        epoch_t      e = ep[find_ep(n)];
        logic [63:0] v = mt_at(n);
        case (idx)
            3'd0:    return v[31:0];
            3'd1:    return v[63:32];
            3'd2:    return e.cmp[31:0];
            3'd3:    return e.cmp[63:32];
            3'd4:    return {30'd0, e.en, e.run};
            3'd5:    return e.p[31:0];
            default: return 32'd0;
        endcase
    endfunction

    function automatic void model_write(input logic [2:0] idx, input logic [31:0] wd, input int d);
        epoch_t      e  = ep[find_ep(d)];
        logic [63:0] v0 = mt_at(d);
        logic [63:0] v1 = mt_at(d + 1);
        e.q  = q_at(d + 1);
        e.n0 = d + 1;
        e.m  = v1;
        case (idx)
            3'd0: e.m = {v0[63:32], wd};
            3'd1: e.m = {wd, v1[31:0]};
            3'd2: e.cmp[31:0]  = wd;
            3'd3: e.cmp[63:32] = wd;
            3'd4: begin e.run = wd[0]; e.en = wd[1]; end
            3'd5: begin e.p = longint'(wd); e.q = 0; end
            default: ;
        endcase
        ep.push_back(e);
    endfunction

    function automatic logic exp_irq(input int n);
        epoch_t e = ep[find_ep(n - 1)];
        return e.en && (mt_at(n - 1) >= e.cmp);
    endfunction

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // Called just after a rising edge; returns just after the rising edge that starts its data phase.
    task automatic issue(input bit wr, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
        int    k = 0;
        int    ac;
        bit    lg;
        exp_t  x;
        sel = 1'b1; addr = a; write = wr; read = !wr; size = sz;
        burst = 3'($urandom); prot = 4'($urandom); mastlock = 1'($urandom);
        @(negedge clk);
        while (!ready && k < 10) begin
            @(posedge clk); #1;
            @(negedge clk);
            k++;
        end
        if (!ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout got ready=0 want ready=1 addr %h", a);
            @(posedge clk); #1;
            sel = 1'b0; read = 1'b0; write = 1'b0;
            return;
        end
        ac = cyc;
        lg = (a[4:2] <= 3'd5) && (sz == 3'd2);
        if (!lg)
            x = '{rd: 32'd0, resp: 1'b1, waits: 1};
        else if (wr) begin
            model_write(a[4:2], wd, ac + 1);
            x = '{rd: 32'd0, resp: 1'b0, waits: 0};
        end else
            x = '{rd: model_read(a[4:2], ac + 1 + WAIT), resp: 1'b0, waits: WAIT};
        sb.push_back(x);
        @(posedge clk); #1;
        sel = 1'b0; read = 1'b0; write = 1'b0; addr = $urandom;
        wdata = wr ? wd : $urandom;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    bit          mon_active = 1'b0;
    int          mon_waits  = 0;
    logic        mon_stall_resp;
    exp_t        mon_exp;

    always @(negedge clk) begin
        if (resetn) begin
            if (mon_active) begin
                if (!ready) begin
                    mon_waits++;
                    mon_stall_resp = resp[0];
                end else begin
                    mon_active = 1'b0;
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL sb_underflow got completion want none");
                    end else begin
                        mon_exp = sb.pop_front();
                        check32("rdata", rdata, mon_exp.rd);
                        check32("resp", 32'(resp[0]), 32'(mon_exp.resp));
                        check32("waits", 32'(mon_waits), 32'(mon_exp.waits));
                        if (mon_waits > 0)
                            check32("stall_resp", 32'(mon_stall_resp), 32'(mon_exp.resp));
                    end
                end
            end
            if (sel && (read || write) && ready) begin
                mon_active = 1'b1;
                mon_waits  = 0;
            end
            checks++;
            if (irq !== exp_irq(cyc)) begin
                errors++;
                $display("FAIL irq cyc %0d got %b want %b", cyc, irq, exp_irq(cyc));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  ridx;
        logic [31:0] raddr, rwd;
        logic [2:0]  rsz;
        bit          rwr;
        ep.push_back('{n0: 0, m: 64'd0, q: 0, p: 0, run: 1'b0, en: 1'b0, cmp: '1});
        resetn = 1'b0; sel = 1'b0; read = 1'b0; write = 1'b0; mastlock = 1'b0;
        addr = '0; wdata = '0; size = 3'd2; burst = '0; prot = '0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        check32("reset_ready", 32'(ready), 32'd1);
        check32("reset_resp", 32'(resp[0]), 32'd0);
        check32("reset_rdata", rdata, 32'd0);
        check32("reset_irq", 32'(irq), 32'd0);
        @(posedge clk); #1;

        issue(0, 32'h08, 3'd2, 0);
        issue(0, 32'h0C, 3'd2, 0);

        issue(1, 32'h14, 3'd2, 32'd3);
        issue(1, 32'h10, 3'd2, 32'd1);
        idle(20);
        issue(0, 32'h00, 3'd2, 0);

        issue(1, 32'h00, 3'd2, 32'hFFFF_FFFE);
        issue(1, 32'h04, 3'd2, 32'd0);
        issue(1, 32'h14, 3'd2, 32'd0);
        idle(3);
        issue(0, 32'h04, 3'd2, 0);
        issue(0, 32'h00, 3'd2, 0);

        issue(1, 32'h10, 3'd2, 32'd0);
        issue(1, 32'h0C, 3'd2, 32'd0);
        issue(1, 32'h08, 3'd2, 32'd10);
        issue(1, 32'h14, 3'd2, 32'd0);
        issue(1, 32'h00, 3'd2, 32'd0);
        issue(1, 32'h04, 3'd2, 32'd0);
        issue(1, 32'h10, 3'd2, 32'd3);
        idle(15);
        issue(1, 32'h08, 3'd2, 32'd100);
        idle(4);

        issue(0, 32'h18, 3'd2, 0);
        issue(0, 32'h00, 3'd0, 0);
        issue(1, 32'h1C, 3'd2, 32'hDEAD_BEEF);
        issue(1, 32'h14, 3'd1, 32'd9);
        issue(0, 32'h14, 3'd2, 0);
        issue(0, 32'h10, 3'd2, 0);

        issue(1, 32'h14, 3'd2, 32'd7);
        issue(0, 32'h14, 3'd2, 0);

        repeat (300) begin
            rwr   = 1'($urandom);
            ridx  = 3'($urandom_range(0, 7));
            rsz   = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'd2;
            raddr = {27'($urandom), ridx, 2'($urandom)};
            if (ridx == 3'd5)      rwd = $urandom_range(0, 3);
            else if (ridx == 3'd4) rwd = $urandom_range(0, 3);
            else if (ridx == 3'd2) rwd = $urandom_range(0, 400);
            else if (ridx == 3'd3) rwd = $urandom_range(0, 1);
            else if (ridx == 3'd1) rwd = $urandom_range(0, 1);
            else                   rwd = $urandom;
            issue(rwr, raddr, rsz, rwd);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
        end

        idle(6);
        checks++;
        if (sb.size() != 0 || mon_active) begin
            errors++;
            $display("FAIL sb_drain got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
